// File: rtl/ws2812_pkg.sv
// ws2812_pkg: shared definitions for the WS2812 frame streamer.
//   state_t            streamer FSM states
//   BYTE_G/BYTE_R/BYTE_B  position of each colour byte within a pixel on the wire
//   holdoff_from_clk() derives a HOLDOFF_CYCLES value from the clock rate and the
//                      shifter's reset tail, for integrators choosing the parameter
package ws2812_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_TRIG,
    S_READ,
    S_LOAD,
    S_SERVE,
    S_END,
    S_HOLDOFF
  } state_t;

  localparam logic [1:0] BYTE_G = 2'd0;
  localparam logic [1:0] BYTE_R = 2'd1;
  localparam logic [1:0] BYTE_B = 2'd2;

  // Reset/latch tail the downstream shifter drives low after a frame.
  localparam int unsigned SHIFTER_TAIL_US = 60;

  // Cycles covering tail_us at clk_hz, rounded up.
  function automatic int unsigned holdoff_from_clk(input int unsigned clk_hz,
                                                   input int unsigned tail_us);
    longint unsigned prod;
    prod = longint'(clk_hz) * longint'(tail_us);
    return int'((prod + 64'd999_999) / 64'd1_000_000);
  endfunction

endpackage

// File: rtl/ws2812_pixel_ram.sv
// ws2812_pixel_ram: NUM_LEDS x 24 pixel store.
//   clk      clock
//   wr_en    write strobe; writes with wr_addr >= NUM_LEDS are dropped
//   wr_addr  write pixel index
//   wr_data  {R,G,B} pixel word
//   rd_en    read strobe
//   rd_addr  read pixel index
//   rd_data  registered read data, 1-cycle latency, read-first on same-address write
module ws2812_pixel_ram #(
  parameter int unsigned NUM_LEDS = 8,
  parameter int unsigned AW       = 3
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [23:0]   wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [23:0]   rd_data
);

  logic [23:0] r_mem [NUM_LEDS];
  logic [23:0] r_rd_data;

  always_ff @(posedge clk) begin
    if (wr_en && (32'(wr_addr) < NUM_LEDS)) r_mem[wr_addr] <= wr_data;
    if (rd_en) r_rd_data <= r_mem[rd_addr];
  end

  assign rd_data = r_rd_data;

endmodule

// File: rtl/ws2812_frame_streamer.sv
// ws2812_frame_streamer: feeds one frame of NUM_LEDS RGB pixels, byte by byte in
// G,R,B order, to the WS2812 output shifter.
//   clk, rst           clock; synchronous active-high reset
//   start / busy       request a frame (honoured only when idle) / frame in progress
//   frame_done         1-cycle pulse at the end of the post-frame holdoff
//   wr_en/addr/data    pixel RAM write port, data {R,G,B}
//   tx_trigger         1-cycle pulse starting the shifter
//   tx_request         shifter asks for the next byte
//   tx_data/tx_valid   current byte; tx_valid=0 on a request ends the frame
// Build option WS2812_BRIGHTNESS_EN adds brightness[7:0]; each colour byte c becomes
// (c*(brightness+1))>>8, sampled when the pixel is loaded.
module ws2812_frame_streamer
  import ws2812_pkg::*;
#(
  parameter  int unsigned NUM_LEDS       = 8,
  parameter  int unsigned HOLDOFF_CYCLES = 800,
  localparam int unsigned AW             = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          busy,
  output logic          frame_done,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [23:0]   wr_data,
  output logic          tx_trigger,
  input  logic          tx_request,
  output logic [7:0]    tx_data,
  output logic          tx_valid
`ifdef WS2812_BRIGHTNESS_EN
  ,
  input  logic [7:0]    brightness
`endif
);

  localparam int unsigned HW        = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;
  localparam logic [HW-1:0] HOLD_INIT = HW'(HOLDOFF_CYCLES - 1);
  localparam logic [AW-1:0] LAST_PIX  = AW'(NUM_LEDS - 1);

  state_t        r_state;
  logic [AW-1:0] r_pix;
  logic [1:0]    r_byte;
  logic [23:0]   r_shift;
  logic [HW-1:0] r_hold;
  logic [7:0]    r_tx_data;
  logic          r_tx_valid;
  logic          r_tx_trigger;
  logic          r_frame_done;
  logic          r_busy;

  logic          w_rd_en;
  logic [23:0]   w_rd_data;
  logic [23:0]   w_pix;

  assign w_rd_en = (r_state == S_READ);

  ws2812_pixel_ram #(
    .NUM_LEDS(NUM_LEDS),
    .AW      (AW)
  ) u_ram (
    .clk    (clk),
    .wr_en  (wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .rd_en  (w_rd_en),
    .rd_addr(r_pix),
    .rd_data(w_rd_data)
  );

`ifdef WS2812_BRIGHTNESS_EN
  function automatic logic [7:0] scale_byte(input logic [7:0] c, input logic [7:0] b);
    logic [16:0] p;
    p = {9'd0, c} * {8'd0, ({1'b0, b} + 9'd1)};
    return p[15:8];
  endfunction

  assign w_pix = {scale_byte(w_rd_data[23:16], brightness),
                  scale_byte(w_rd_data[15:8],  brightness),
                  scale_byte(w_rd_data[7:0],   brightness)};
`else
  assign w_pix = w_rd_data;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_pix        <= '0;
      r_byte       <= BYTE_G;
      r_shift      <= '0;
      r_hold       <= '0;
      r_tx_data    <= '0;
      r_tx_valid   <= 1'b0;
      r_tx_trigger <= 1'b0;
      r_frame_done <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_tx_trigger <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          r_frame_done <= 1'b0;
          if (start) begin
            r_state      <= S_TRIG;
            r_tx_trigger <= 1'b1;
            r_busy       <= 1'b1;
          end
        end
        S_TRIG: begin
          r_pix   <= '0;
          r_state <= S_READ;
        end
        S_READ: begin
          r_tx_valid <= 1'b0;
          r_state    <= S_LOAD;
        end
        S_LOAD: begin
          // Shift register holds the pixel in wire order {G,R,B}.
          r_shift    <= {w_pix[15:8], w_pix[23:16], w_pix[7:0]};
          r_tx_data  <= w_pix[15:8];
          r_tx_valid <= 1'b1;
          r_byte     <= BYTE_G;
          r_state    <= S_SERVE;
        end
        S_SERVE: begin
          if (tx_request) begin
            if (r_byte != BYTE_B) begin
              r_shift   <= {r_shift[15:0], 8'd0};
              r_tx_data <= r_shift[15:8];
              r_byte    <= r_byte + 2'd1;
            end else if (r_pix != LAST_PIX) begin
              r_pix      <= r_pix + 1'b1;
              r_tx_valid <= 1'b0;
              r_state    <= S_READ;
            end else begin
              r_tx_valid <= 1'b0;
              r_tx_data  <= '0;
              r_state    <= S_END;
            end
          end
        end
        S_END: begin
          if (tx_request) begin
            r_hold       <= HOLD_INIT;
            // frame_done is registered, so it is raised on the cycle the counter reaches 0.
            r_frame_done <= (HOLDOFF_CYCLES <= 1);
            r_state      <= S_HOLDOFF;
          end
        end
        S_HOLDOFF: begin
          if (r_hold == '0) begin
            r_frame_done <= 1'b0;
            r_busy       <= 1'b0;
            r_state      <= S_IDLE;
          end else begin
            r_hold       <= r_hold - 1'b1;
            r_frame_done <= (r_hold == HW'(1));
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy       = r_busy;
  assign frame_done = r_frame_done;
  assign tx_trigger = r_tx_trigger;
  assign tx_data    = r_tx_data;
  assign tx_valid   = r_tx_valid;

endmodule
